// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard unit: the per-stage
// tracker entry, the NOP encoding used on flush and the register-file select code.
package pipe_pkg;

  // Destination indices are stored zero-extended to this width, so REG_AW may not exceed it.
  localparam int RD_MAXW = 8;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic               valid;
    logic               reg_wr;
    logic               is_load;
    logic [RD_MAXW-1:0] rd;
  } trk_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Priority search of the tracker for one decode operand; the youngest
// matching producer wins and its stage number and load flag are reported.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REG_AW  = 5,
  parameter int FW      = $clog2(NSTAGES + 1)
) (
  input  trk_entry_t [NSTAGES-1:0] trk,
  input  logic [REG_AW-1:0]        rs,
  input  logic                     rs_used,
  output logic                     hit,
  output logic [FW-1:0]            k,
  output logic                     is_load
);

  // Scan oldest to youngest so the last (smallest k) match overwrites the rest.
  always_comb begin
    hit     = 1'b0;
    k       = FW'(FWD_RF);
    is_load = 1'b0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      if (trk[i].valid && trk[i].reg_wr && rs_used && (rs != '0) &&
          (trk[i].rd == RD_MAXW'(rs))) begin
        hit     = 1'b1;
        k       = FW'(i + 1);
        is_load = trk[i].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, branch flush and forwarding-select generation for an
// in-order pipeline, driven by a shift register tracking issued instructions.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2,
  parameter int FW         = $clog2(NSTAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic [FW-1:0]     fwd_sel1,
  output logic [FW-1:0]     fwd_sel2,
  output logic [15:0]       stall_cnt
);

  // Element i describes the instruction that left decode i+1 cycles ago.
  trk_entry_t [NSTAGES-1:0] trk;
  trk_entry_t               new_entry;

  logic          hit1, hit2, ld1, ld2;
  logic [FW-1:0] k1, k2;
  logic          hz1, hz2;

  fwd_match #(.NSTAGES(NSTAGES), .REG_AW(REG_AW), .FW(FW)) u_match1 (
    .trk     (trk),
    .rs      (id_rs1),
    .rs_used (id_rs1_used),
    .hit     (hit1),
    .k       (k1),
    .is_load (ld1)
  );

  fwd_match #(.NSTAGES(NSTAGES), .REG_AW(REG_AW), .FW(FW)) u_match2 (
    .trk     (trk),
    .rs      (id_rs2),
    .rs_used (id_rs2_used),
    .hit     (hit2),
    .k       (k2),
    .is_load (ld2)
  );

  // A load is only a hazard if it is the youngest producer and its data is not yet on a bus.
  always_comb begin
    hz1      = hit1 & ld1 & (int'(k1) < LOAD_STAGE);
    hz2      = hit2 & ld2 & (int'(k2) < LOAD_STAGE);
    flush    = br_taken & ~rst;
    stall    = id_valid & (hz1 | hz2) & ~br_taken & ~rst;
    issue    = id_valid & ~stall & ~flush & ~rst;
    fwd_sel1 = rst ? FW'(FWD_RF) : k1;
    fwd_sel2 = rst ? FW'(FWD_RF) : k2;
  end

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = issue;
    new_entry.reg_wr  = issue & id_reg_wr;
    new_entry.is_load = issue & id_is_load;
    new_entry.rd      = issue ? RD_MAXW'(id_rd) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk <= '0;
    end else begin
      for (int i = NSTAGES - 1; i > 0; i--) begin
        trk[i] <= trk[i-1];
      end
      trk[0] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: directed vector table, randomized run against a queue-based
// reference model, and a long saturation run on a deep-pipeline instance.
module tb_pipe_hazard_unit;

  localparam int NS = 3;
  localparam int LS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, flush, issue;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [15:0] stall_cnt;

  logic       s_rst;
  logic       s_stall, s_flush, s_issue;
  logic [3:0] s_sel1, s_sel2;
  logic [15:0] s_cnt;
  bit         sat_done = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.NSTAGES(NS), .REG_AW(5), .LOAD_STAGE(LS)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall), .flush(flush), .issue(issue), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  // Deep instance: a self-dependent load stalls 7 of every 8 cycles, reaching saturation quickly.
  pipe_hazard_unit #(.NSTAGES(8), .REG_AW(5), .LOAD_STAGE(8)) dut_sat (
    .clk(clk), .rst(s_rst), .id_valid(1'b1), .id_rs1(5'd6), .id_rs2(5'd0),
    .id_rs1_used(1'b1), .id_rs2_used(1'b0), .id_rd(5'd6), .id_reg_wr(1'b1),
    .id_is_load(1'b1), .br_taken(1'b0), .stall(s_stall), .flush(s_flush),
    .issue(s_issue), .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .stall_cnt(s_cnt)
  );

  typedef struct {
    bit rst, valid, u1, u2, wr, ld, br;
    int rs1, rs2, rd;
  } stim_t;

  typedef struct {
    stim_t s;
    bit    e_stall, e_flush, e_issue;
    int    e_sel1, e_sel2, e_cnt;
  } vec_t;

  typedef struct {
    bit valid, wr, ld;
    int rd;
  } hist_t;

  vec_t  tbl[$];
  hist_t hist[$];
  int    m_cnt;

  function automatic stim_t st(bit r, bit v, int rs1, bit u1, int rs2, bit u2,
                               int rd, bit wr, bit ld, bit br);
    stim_t s;
    s.rst = r; s.valid = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.wr = wr; s.ld = ld; s.br = br;
    return s;
  endfunction

  function automatic vec_t vc(stim_t s, bit es, bit ef, bit ei, int s1, int s2, int c);
    vec_t v;
    v.s = s; v.e_stall = es; v.e_flush = ef; v.e_issue = ei;
    v.e_sel1 = s1; v.e_sel2 = s2; v.e_cnt = c;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; id_valid = s.valid;
    id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2);
    id_rs1_used = s.u1; id_rs2_used = s.u2;
    id_rd = 5'(s.rd); id_reg_wr = s.wr; id_is_load = s.ld; br_taken = s.br;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input bit es, input bit ef, input bit ei,
                          input int s1, input int s2, input int c);
    checkOutput({tag, " stall"}, int'(stall), int'(es));
    checkOutput({tag, " flush"}, int'(flush), int'(ef));
    checkOutput({tag, " issue"}, int'(issue), int'(ei));
    checkOutput({tag, " fwd_sel1"}, int'(fwd_sel1), s1);
    checkOutput({tag, " fwd_sel2"}, int'(fwd_sel2), s2);
    if (c >= 0) checkOutput({tag, " stall_cnt"}, int'(stall_cnt), c);
  endtask

  // Reference: youngest issued record (queue front = one cycle ago) writing rs.
  function automatic int m_sel(int rs, bit used);
    for (int k = 1; k <= hist.size(); k++) begin
      if (hist[k-1].valid && hist[k-1].wr && hist[k-1].rd == rs && rs != 0 && used)
        return k;
    end
    return 0;
  endfunction

  function automatic bit m_loaduse(int k);
    return (k != 0) && hist[k-1].ld && (k < LS);
  endfunction

  initial begin
    stim_t s;
    bit    es, ef, ei;
    int    s1, s2;
    hist_t h;

    applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tbl.push_back(vc(st(1,1, 6,1, 6,1, 6,1,1,1), 0,0,0, 0,0, -1));
    tbl.push_back(vc(st(1,1, 6,1, 6,1, 6,1,1,1), 0,0,0, 0,0, 0));
    tbl.push_back(vc(st(0,1, 1,1, 2,1, 5,1,0,0), 0,0,1, 0,0, 0));
    tbl.push_back(vc(st(0,1, 5,1, 3,1, 8,1,0,0), 0,0,1, 1,0, 0));
    tbl.push_back(vc(st(0,1, 5,1, 0,1, 6,1,1,0), 0,0,1, 2,0, 0));
    tbl.push_back(vc(st(0,1, 9,1, 6,1,10,1,0,0), 1,0,0, 0,1, 0));
    tbl.push_back(vc(st(0,1, 9,1, 6,1,10,1,0,0), 0,0,1, 0,2, 1));
    tbl.push_back(vc(st(0,1, 0,0, 0,0, 7,1,0,0), 0,0,1, 0,0, 1));
    tbl.push_back(vc(st(0,1, 7,1, 0,0,11,1,0,0), 0,0,1, 1,0, 1));
    tbl.push_back(vc(st(0,1, 7,1,10,1, 7,1,0,0), 0,0,1, 2,3, 1));
    tbl.push_back(vc(st(0,1, 7,1, 7,1,12,1,0,0), 0,0,1, 1,1, 1));
    tbl.push_back(vc(st(0,1,12,1, 0,0, 0,1,0,0), 0,0,1, 1,0, 1));
    tbl.push_back(vc(st(0,1, 0,1, 7,1,13,0,0,0), 0,0,1, 0,3, 1));
    tbl.push_back(vc(st(0,1,13,1,12,0,14,1,1,0), 0,0,1, 0,0, 1));
    tbl.push_back(vc(st(0,1,14,1, 0,0,15,1,0,1), 0,1,0, 1,0, 1));
    tbl.push_back(vc(st(0,0,14,1,15,1, 0,0,0,0), 0,0,0, 2,0, 1));
    tbl.push_back(vc(st(0,1,14,1, 0,0, 6,1,1,0), 0,0,1, 3,0, 1));
    tbl.push_back(vc(st(0,1, 0,0, 6,1, 9,1,1,0), 1,0,0, 0,1, 1));
    tbl.push_back(vc(st(1,1, 0,0, 6,1, 9,1,1,0), 0,0,0, 0,0, 2));
    tbl.push_back(vc(st(0,1, 0,0, 6,1, 9,1,1,0), 0,0,1, 0,0, 0));
    tbl.push_back(vc(st(0,1, 0,0, 0,0, 9,1,0,0), 0,0,1, 0,0, 0));
    tbl.push_back(vc(st(0,1, 9,1, 9,1, 1,1,0,0), 0,0,1, 1,1, 0));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s);
      #3;
      checkAll($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_issue,
               tbl[i].e_sel1, tbl[i].e_sel2, tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    // Randomized run; first cycle forces reset so the model starts from a known state.
    hist.delete();
    m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      s = st((c == 0) || ($urandom_range(0, 63) == 0), $urandom_range(0, 7) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      applyStimulus(s);
      s1 = m_sel(s.rs1, s.u1);
      s2 = m_sel(s.rs2, s.u2);
      ef = s.br && !s.rst;
      es = s.valid && (m_loaduse(s1) || m_loaduse(s2)) && !s.br && !s.rst;
      ei = s.valid && !es && !ef && !s.rst;
      if (s.rst) begin s1 = 0; s2 = 0; end
      #3;
      checkAll($sformatf("rnd%0d", c), es, ef, ei, s1, s2, (c == 0) ? -1 : m_cnt);
      @(posedge clk);
      if (s.rst) begin
        hist.delete();
        m_cnt = 0;
      end else begin
        h.valid = ei; h.wr = ei && s.wr; h.ld = ei && s.ld; h.rd = s.rd;
        hist.push_front(h);
        if (hist.size() > NS) void'(hist.pop_back());
        if (es && m_cnt < 65535) m_cnt++;
      end
      #1;
    end

    for (int i = 0; i < 100000 && !sat_done; i++) @(posedge clk);
    checkOutput("sat_done", int'(sat_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Saturation: edge 0 issues, edges 1..7 stall, repeating; 7 stalls per 8 edges.
  initial begin
    s_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b0;
    repeat (8000) @(posedge clk);
    #1;
    checkOutput("sat stall_cnt mid", int'(s_cnt), 7000);
    repeat (68000) @(posedge clk);
    #1;
    checkOutput("sat stall_cnt full", int'(s_cnt), 65535);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("sat stall_cnt hold", int'(s_cnt), 65535);
    sat_done = 1'b1;
  end

endmodule
